reg_pipeline_async_reset: RTL
=============================

Name: reg_pipeline_async_reset

Overview:
- Parametrised successor to the single-bit async-reset D flip-flop.
- A DEPTH-stage, WIDTH-bit register pipeline with a valid/ready handshake, per-stage backpressure, synchronous flush and an occupancy count.
- Used as a generic retiming/delay element between streaming blocks, replacing hand-chained DFFs.
- Every storage element resets asynchronously.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 4, number of register stages (>=1); also the no-stall latency in cycles.
- RESET_VAL, '0 (WIDTH bits), value loaded into every stage data register on reset.
- FLUSH_CLEARS_DATA, 1, when 1 flush also loads RESET_VAL into data registers; when 0 flush clears valids only.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous pipeline clear.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  pipeline can accept in_data this cycle.
- in_data  input  WIDTH  upstream data.
- out_valid  output  1  stage DEPTH-1 holds valid data.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  WIDTH  data of stage DEPTH-1.
- occupancy  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- One clock (clk); reset is asynchronous and active-high, named reset.
- Reset assertion, immediately and without a clock edge:
  - all stage valids = 0, all stage data = RESET_VAL;
  - out_valid=0, out_data=RESET_VAL, occupancy=0, in_ready=0 (in_ready is forced low while reset is high).
- After reset deasserts: in_ready=1 on the first cycle.
- Stage i holds {v[i], d[i]}. Downstream ready of the last stage is out_ready; the upstream "valid" of stage 0 is in_valid.
- Stage enable: en[i] = !v[i] || rdy[i+1], where rdy[DEPTH] = out_ready.
- in_ready = en[0] && !flush && !reset.
  - The ready chain is combinational, giving full throughput and no bubbles.
- On a clock edge with en[i]=1 and flush=0:
  - v[i] <= v[i-1] (stage 0: in_valid && in_ready);
  - d[i] <= d[i-1] (stage 0: in_data).
  - d[i] loads only when the incoming valid is 1; otherwise d[i] holds.
- On a clock edge with en[i]=0: the stage holds.
  - out_data and out_valid stay stable while out_valid && !out_ready.
- Latency: a word accepted at edge N appears on out_valid/out_data after edge N+DEPTH-1 (visible DEPTH cycles after acceptance) when not stalled. Throughput is 1 word/cycle.
- Stall: with out_ready=0 the pipeline fills. When all DEPTH stages are valid, in_ready=0. No data is lost or duplicated.
- Drain: when out_ready is 1 with a full pipe, a new word can be accepted in the same cycle (simultaneous push/pop); occupancy is unchanged.
- flush=1 at an edge:
  - all v[i] <= 0;
  - d[i] <= RESET_VAL if FLUSH_CLEARS_DATA=1, else d[i] holds;
  - no input is accepted that edge (flush overrides in_valid);
  - out_valid may still be high during the flush cycle and the word counts as transferred if out_ready=1.
- occupancy = popcount of v[]. It is combinational from the registers, range 0..DEPTH, and updates the cycle after each edge.
- Reset mid-operation: all in-flight data is discarded immediately. Nothing is emitted after reset releases until new input is accepted.
- in_data is don't-care when in_valid=0 or in_ready=0.
- X on in_data must not propagate into d[] when not accepted.

Decomposition:
- Shared package reg_pipe_pkg holds the occupancy width function (clog2(DEPTH+1)).
- One sub-module, reg_pipe_stage:
  - a WIDTH-bit valid+data register with async reset to RESET_VAL;
  - inputs en, flush, up_valid, up_data;
  - outputs valid, data.
- Top instantiates DEPTH stages in a generate loop and builds the ready chain and popcount.

Test Plan:
- Reset: assert reset mid-cycle with WIDTH=8, DEPTH=4, RESET_VAL=8'hA5 -> immediately out_valid=0, out_data=8'hA5, occupancy=0, in_ready=0; after release in_ready=1.
- Streaming: out_ready=1, push 8'h01..8'h08 on consecutive cycles -> out_data 8'h01..8'h08 on consecutive cycles, first one 4 cycles after acceptance; occupancy steady at 4.
- Backpressure: out_ready=0, push 8'h10,11,12,13,14 -> first 4 accepted, in_ready=0 on the fifth, occupancy=4, out_data holds 8'h10; raise out_ready -> 8'h10..8'h14 in order, none lost.
- Flush: pipe holding 3 words, flush=1 with in_valid=1, in_data=8'h55 -> next cycle occupancy=0, out_valid=0, 8'h55 not accepted, out_data=8'hA5 (FLUSH_CLEARS_DATA=1).
- Reset mid-stream: 4 words in flight, pulse reset between clock edges -> outputs clear instantly; after release, push 8'h77 -> only 8'h77 emitted, 4 cycles later.
- Full push/pop: full pipe, out_ready=1 and in_valid=1 every cycle -> one word in and one out per cycle, occupancy stays 4, order preserved.

Source files
------------

// File: rtl/reg_pipe_pkg.sv
// rtl/reg_pipe_pkg.sv - shared helpers for the register pipeline
//
// Purpose: holds the occupancy-width function so the top and any consumer
// size the occupancy count identically.
// Ports: none (package).
package reg_pipe_pkg;

    // Occupancy must represent 0..depth inclusive, hence depth+1 values.
    function automatic int occ_width(input int depth);
        int w;
        w = $clog2(depth + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// rtl/reg_pipe_stage.sv - one valid+data register stage of the pipeline
//
// Purpose: a single {valid, data} register with asynchronous reset.
// Ports:
//   clk      - rising-edge clock
//   reset    - asynchronous active-high reset
//   en       - stage may take new contents this edge
//   flush    - synchronous clear (overrides en)
//   up_valid - valid of the upstream stage
//   up_data  - data of the upstream stage
//   valid    - stage holds valid data
//   data     - stage data
module reg_pipe_stage #(
    parameter int               WIDTH             = 8,
    parameter logic [WIDTH-1:0] RESET_VAL         = '0,
    parameter bit               FLUSH_CLEARS_DATA = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VAL;
        end else if (flush) begin
            valid_q <= 1'b0;
            if (FLUSH_CLEARS_DATA) begin
                data_q <= RESET_VAL;
            end
        end else if (en) begin
            valid_q <= up_valid;
            // Data only loads with a valid word so X on an idle bus never
            // reaches the register.
            if (up_valid) begin
                data_q <= up_data;
            end
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/reg_pipeline_async_reset.sv
// rtl/reg_pipeline_async_reset.sv - DEPTH-stage valid/ready register pipeline
//
// Purpose: generic retiming/delay element with per-stage backpressure,
// synchronous flush and an occupancy count; all storage resets asynchronously.
// Ports:
//   clk       - rising-edge clock
//   reset     - asynchronous active-high reset
//   flush     - synchronous clear of all stages, blocks input that edge
//   in_valid  - upstream data valid
//   in_ready  - pipeline accepts in_data this cycle
//   in_data   - upstream data
//   out_valid - last stage holds valid data
//   out_ready - downstream accepts out_data this cycle
//   out_data  - last stage data
//   occupancy - number of valid stages (0..DEPTH)
module reg_pipeline_async_reset
    import reg_pipe_pkg::*;
#(
    parameter int               WIDTH             = 8,
    parameter int               DEPTH             = 4,
    parameter logic [WIDTH-1:0] RESET_VAL         = '0,
    parameter bit               FLUSH_CLEARS_DATA = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic [occ_width(DEPTH)-1:0]   occupancy
);

    localparam int OCC_W = occ_width(DEPTH);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH:0]   rdy;
    logic             push;

    // Ready ripples back from the output: a stage can load when it is empty
    // or when its successor is loading this same edge.
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy[i] = !v[i] || rdy[i + 1];
        end
    end

    assign in_ready = rdy[0] && !flush && !reset;
    assign push     = in_valid && in_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_valid;
        logic [WIDTH-1:0] up_data;

        if (i == 0) begin : g_first
            assign up_valid = push;
            assign up_data  = in_data;
        end else begin : g_rest
            assign up_valid = v[i - 1];
            assign up_data  = d[i - 1];
        end

        reg_pipe_stage #(
            .WIDTH            (WIDTH),
            .RESET_VAL        (RESET_VAL),
            .FLUSH_CLEARS_DATA(FLUSH_CLEARS_DATA)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .en      (rdy[i]),
            .flush   (flush),
            .up_valid(up_valid),
            .up_data (up_data),
            .valid   (v[i]),
            .data    (d[i])
        );
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(v[i]);
        end
    end

    assign out_valid = v[DEPTH - 1];
    assign out_data  = d[DEPTH - 1];

endmodule
